// File: rtl/cache_dma_bridge_if.sv
// Word-wide memory bus between cache_dma_bridge (master) and the memory (slave).
// One beat in flight; read data returns on mem_rvalid_i after the handshake.
interface cache_dma_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_W  = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [MEM_W-1:0]  mem_wdata_o;
  logic              mem_ready_i;
  logic [MEM_W-1:0]  mem_rdata_i;
  logic              mem_rvalid_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i, mem_rvalid_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i, mem_rvalid_i
  );
endinterface

// File: rtl/cache_dma_bridge.sv
// Cache refill / eviction engine over a word-wide memory bus: blocks are split into
// MEM_W beats (beat 0 = LSBs). Define CACHE_DMA_BRIDGE_PERF_EN for fill/evict/stall counters.
module cache_dma_bridge #(
  parameter int BLOCK_BITS = 512,
  parameter int MEM_W      = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic                  req_i,
  input  logic [ADDR_W-1:0]     ev_addr_i,
  input  logic [BLOCK_BITS-1:0] ev_data_i,
  input  logic                  ev_i,
  output logic [BLOCK_BITS-1:0] fill_data_o,
  output logic [ADDR_W-1:0]     fill_addr_o,
  output logic                  fill_valid_o,
  output logic                  ev_done_o,
  cache_dma_bridge_if.master    mem
`ifdef CACHE_DMA_BRIDGE_PERF_EN
  ,
  output logic [15:0]           fill_cnt_o,
  output logic [15:0]           ev_cnt_o,
  output logic [15:0]           stall_cnt_o
`endif
);

  localparam int BEATS   = BLOCK_BITS / MEM_W;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BLK_OFF = $clog2(BLOCK_BITS / 8);
  localparam int WRD_OFF = $clog2(MEM_W / 8);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << BLK_OFF) - ADDR_W'(1));

  typedef enum logic [2:0] {IDLE, EV_BEAT, FL_BEAT, FL_WAIT, EV_DONE, FL_DONE} state_t;

  state_t                r_state, w_next;
  logic [BEAT_W-1:0]     r_beat;
  logic [ADDR_W-1:0]     r_base;
  logic [BLOCK_BITS-1:0] r_ev_data;
  logic [BLOCK_BITS-1:0] r_buf;
  logic [BLOCK_BITS-1:0] r_fill_data;
  logic [ADDR_W-1:0]     r_fill_addr;
  logic                  r_ev_arm, r_rq_arm;

  logic                  w_acc_ev, w_acc_fl, w_hs, w_last, w_store;
  logic [ADDR_W-1:0]     w_beat_addr;
  logic [BLOCK_BITS-1:0] w_buf_next;

  // Eviction wins a tie so a dirty block is written back before an aliasing refill reads it.
  assign w_acc_ev    = (r_state == IDLE) && ev_i && r_ev_arm;
  assign w_acc_fl    = (r_state == IDLE) && !w_acc_ev && req_i && r_rq_arm;
  assign w_hs        = mem.mem_req_o && mem.mem_ready_i;
  assign w_last      = (r_beat == BEAT_W'(BEATS - 1));
  assign w_store     = (r_state == FL_WAIT) && mem.mem_rvalid_i;
  assign w_beat_addr = r_base + (ADDR_W'(r_beat) << WRD_OFF);

  assign fill_data_o = r_fill_data;
  assign fill_addr_o = r_fill_addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_acc_ev)      w_next = EV_BEAT;
        else if (w_acc_fl) w_next = FL_BEAT;
      end
      EV_BEAT: if (w_hs && w_last) w_next = EV_DONE;
      EV_DONE: w_next = IDLE;
      FL_BEAT: if (w_hs) w_next = FL_WAIT;
      FL_WAIT: if (mem.mem_rvalid_i) w_next = w_last ? FL_DONE : FL_BEAT;
      FL_DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = '0;
    ev_done_o       = 1'b0;
    fill_valid_o    = 1'b0;
    case (r_state)
      EV_BEAT: begin
        mem.mem_req_o   = 1'b1;
        mem.mem_we_o    = 1'b1;
        mem.mem_addr_o  = w_beat_addr;
        mem.mem_wdata_o = r_ev_data[int'(r_beat) * MEM_W +: MEM_W];
      end
      FL_BEAT: begin
        mem.mem_req_o  = 1'b1;
        mem.mem_addr_o = w_beat_addr;
      end
      EV_DONE: ev_done_o    = 1'b1;
      FL_DONE: fill_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[int'(r_beat) * MEM_W +: MEM_W] = mem.mem_rdata_i;
  end

  // Refill data gathers in r_buf and is published only on the last beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_beat      <= '0;
      r_base      <= '0;
      r_ev_data   <= '0;
      r_buf       <= '0;
      r_fill_data <= '0;
      r_fill_addr <= '0;
      r_ev_arm    <= 1'b1;
      r_rq_arm    <= 1'b1;
    end else begin
      if (w_acc_ev) begin
        r_base    <= ev_addr_i & BLK_MASK;
        r_ev_data <= ev_data_i;
        r_beat    <= '0;
      end else if (w_acc_fl) begin
        r_base <= req_addr_i & BLK_MASK;
        r_beat <= '0;
      end
      if ((r_state == EV_BEAT) && w_hs && !w_last) r_beat <= r_beat + 1'b1;
      if (w_store) begin
        r_buf <= w_buf_next;
        if (w_last) begin
          r_fill_data <= w_buf_next;
          r_fill_addr <= r_base;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      if (w_acc_ev)  r_ev_arm <= 1'b0;
      else if (!ev_i) r_ev_arm <= 1'b1;
      if (w_acc_fl)   r_rq_arm <= 1'b0;
      else if (!req_i) r_rq_arm <= 1'b1;
    end
  end

`ifdef CACHE_DMA_BRIDGE_PERF_EN
  logic [15:0] r_fill_cnt, r_ev_cnt, r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fill_cnt  <= '0;
      r_ev_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (fill_valid_o) r_fill_cnt <= r_fill_cnt + 16'd1;
      if (ev_done_o)    r_ev_cnt   <= r_ev_cnt + 16'd1;
      if (mem.mem_req_o && !mem.mem_ready_i) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign fill_cnt_o  = r_fill_cnt;
  assign ev_cnt_o    = r_ev_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cache_dma_bridge.sv
// Randomized self-checking bench for cache_dma_bridge against a block-level reference model
// and a memory model with configurable per-beat back-pressure.
module tb_cache_dma_bridge;
  localparam int BLOCK_BITS = 512;
  localparam int MEM_W      = 32;
  localparam int ADDR_W     = 32;
  localparam int BEATS      = BLOCK_BITS / MEM_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0]     req_addr_i = '0;
  logic                  req_i      = 1'b0;
  logic [ADDR_W-1:0]     ev_addr_i  = '0;
  logic [BLOCK_BITS-1:0] ev_data_i  = '0;
  logic                  ev_i       = 1'b0;
  logic [BLOCK_BITS-1:0] fill_data_o;
  logic [ADDR_W-1:0]     fill_addr_o;
  logic                  fill_valid_o;
  logic                  ev_done_o;
`ifdef CACHE_DMA_BRIDGE_PERF_EN
  logic [15:0] fill_cnt_o, ev_cnt_o, stall_cnt_o;
`endif

  cache_dma_bridge_if #(.ADDR_W(ADDR_W), .MEM_W(MEM_W)) mem_if ();

  cache_dma_bridge #(.BLOCK_BITS(BLOCK_BITS), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_addr_i   (req_addr_i),
    .req_i        (req_i),
    .ev_addr_i    (ev_addr_i),
    .ev_data_i    (ev_data_i),
    .ev_i         (ev_i),
    .fill_data_o  (fill_data_o),
    .fill_addr_o  (fill_addr_o),
    .fill_valid_o (fill_valid_o),
    .ev_done_o    (ev_done_o),
    .mem          (mem_if.master)
`ifdef CACHE_DMA_BRIDGE_PERF_EN
    ,
    .fill_cnt_o   (fill_cnt_o),
    .ev_cnt_o     (ev_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: every beat waits stall_n cycles for ready; reads return addr ^ salt next cycle.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       log_q[$];
  int          stall_n = 0;
  int          wcnt    = 0;
  logic [31:0] salt    = '0;

  assign mem_if.mem_ready_i = (wcnt >= stall_n);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_if.mem_rvalid_i <= 1'b0;
      mem_if.mem_rdata_i  <= '0;
      wcnt                <= 0;
    end else begin
      mem_if.mem_rvalid_i <= 1'b0;
      if (mem_if.mem_req_o && mem_if.mem_ready_i) begin
        wcnt <= 0;
        if (mem_if.mem_we_o) begin
          log_q.push_back('{1'b1, mem_if.mem_addr_o, mem_if.mem_wdata_o});
        end else begin
          log_q.push_back('{1'b0, mem_if.mem_addr_o, mem_if.mem_addr_o ^ salt});
          mem_if.mem_rvalid_i <= 1'b1;
          mem_if.mem_rdata_i  <= mem_if.mem_addr_o ^ salt;
        end
      end else if (mem_if.mem_req_o) begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Stalled beats must hold request, address and data; done pulses are tallied.
  logic        p_stall = 1'b0;
  logic [31:0] p_addr  = '0;
  logic [31:0] p_wdata = '0;
  int          n_fill  = 0;
  int          n_evd   = 0;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      p_stall <= 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_req", mem_if.mem_req_o, 1'b1);
        chk("hold_addr", mem_if.mem_addr_o, p_addr);
        chk("hold_wdata", mem_if.mem_wdata_o, p_wdata);
      end
      p_stall <= mem_if.mem_req_o && !mem_if.mem_ready_i;
      p_addr  <= mem_if.mem_addr_o;
      p_wdata <= mem_if.mem_wdata_o;
      n_fill  <= n_fill + int'(fill_valid_o);
      n_evd   <= n_evd + int'(ev_done_o);
    end
  end

  int exp_fill = 0;
  int exp_evd  = 0;

  function automatic logic [31:0] blk_base(input logic [31:0] a);
    return a & ~32'(BLOCK_BITS / 8 - 1);
  endfunction

  // Cycle index (1 = cycle the request was raised) at which the chosen pulse is seen; -1 on timeout.
  task automatic wait_pulse(input bit is_fill, input int maxc, output int cyc);
    cyc = 1;
    forever begin
      @(negedge clk);
      if (is_fill ? fill_valid_o : ev_done_o) return;
      if (cyc >= maxc) begin
        cyc = -1;
        return;
      end
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic chk_log(input int first, input bit we, input logic [31:0] base,
                         input logic [511:0] d);
    for (int k = 0; k < BEATS; k++) begin
      if (first + k < log_q.size()) begin
        chk("log_we", log_q[first + k].we, we);
        chk("log_addr", log_q[first + k].addr, base + 32'(4 * k));
        if (we) chk("log_wdata", log_q[first + k].data, d[k * 32 +: 32]);
      end
    end
  endtask

  task automatic run_evict(input logic [31:0] a, input logic [511:0] d, input int stl);
    int cyc;
`ifdef CACHE_DMA_BRIDGE_PERF_EN
    logic [15:0] s0 = stall_cnt_o;
`endif
    log_q.delete();
    stall_n = stl;
    @(posedge clk); #1;
    ev_addr_i = a;
    ev_data_i = d;
    ev_i      = 1'b1;
    wait_pulse(1'b0, 100 + 40 * stl, cyc);
    exp_evd++;
    chk("ev_latency", cyc, 2 + BEATS + BEATS * stl);
    chk("ev_nbeats", log_q.size(), BEATS);
    chk_log(0, 1'b1, blk_base(a), d);
`ifdef CACHE_DMA_BRIDGE_PERF_EN
    chk("ev_stall_cnt", stall_cnt_o - s0, 16'(BEATS * stl));
`endif
    @(posedge clk); #1;
    ev_i = 1'b0;
    @(negedge clk);
    chk("ev_done_width", ev_done_o, 1'b0);
  endtask

  task automatic finish_fill(input logic [31:0] a, input int stl, input bit keep);
    int cyc;
    logic [511:0] exp_blk;
    logic [31:0]  b = blk_base(a);
`ifdef CACHE_DMA_BRIDGE_PERF_EN
    logic [15:0] s0 = stall_cnt_o;
`endif
    for (int k = 0; k < BEATS; k++) exp_blk[k * 32 +: 32] = (b + 32'(4 * k)) ^ salt;
    wait_pulse(1'b1, 100 + 40 * stl, cyc);
    exp_fill++;
    chk("fill_latency", cyc, 2 + 2 * BEATS + BEATS * stl);
    chk("fill_addr", fill_addr_o, b);
    chk("fill_data", fill_data_o, exp_blk);
    chk("fill_nbeats", log_q.size(), BEATS);
    chk_log(0, 1'b0, b, '0);
`ifdef CACHE_DMA_BRIDGE_PERF_EN
    chk("fill_stall_cnt", stall_cnt_o - s0, 16'(BEATS * stl));
`endif
    @(posedge clk); #1;
    if (!keep) req_i = 1'b0;
    @(negedge clk);
    chk("fill_valid_width", fill_valid_o, 1'b0);
    chk("fill_data_hold", fill_data_o, exp_blk);
  endtask

  task automatic run_fill(input logic [31:0] a, input int stl, input logic [31:0] sl,
                          input bit keep);
    log_q.delete();
    stall_n = stl;
    salt    = sl;
    @(posedge clk); #1;
    req_addr_i = a;
    req_i      = 1'b1;
    finish_fill(a, stl, keep);
  endtask

  initial begin
    logic [511:0] blk;
    int           cyc;
    int           nreq;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_if.mem_req_o, 1'b0);
    chk("rst_mem_we", mem_if.mem_we_o, 1'b0);
    chk("rst_mem_addr", mem_if.mem_addr_o, '0);
    chk("rst_fill_valid", fill_valid_o, 1'b0);
    chk("rst_ev_done", ev_done_o, 1'b0);
    chk("rst_fill_data", fill_data_o, '0);
    chk("rst_fill_addr", fill_addr_o, '0);
    rst = 1'b0;

    // Directed refill and eviction from the block's usage examples.
    run_fill(32'h0000_1234, 0, 32'h0, 1'b0);
    chk("tp_fill_lo", fill_data_o[31:0], 32'h1200);
    chk("tp_fill_hi", fill_data_o[511:480], 32'h123C);
    for (int k = 0; k < BEATS; k++) blk[k * 32 +: 32] = 32'hA000_0000 + 32'(k);
    run_evict(32'h0000_2040, blk, 0);

    // Back-pressure: three idle-ready cycles per beat.
    run_evict(32'h0000_2040, blk, 3);
    run_fill(32'h0000_1234, 3, 32'h5A5A_0F0F, 1'b0);

    // Simultaneous eviction and refill of the same block: write-back first.
    log_q.delete();
    stall_n = 0;
    salt    = 32'h0;
    for (int k = 0; k < BEATS; k++) blk[k * 32 +: 32] = $urandom;
    @(posedge clk); #1;
    ev_addr_i  = 32'h0000_3000;
    ev_data_i  = blk;
    req_addr_i = 32'h0000_3000;
    ev_i       = 1'b1;
    req_i      = 1'b1;
    wait_pulse(1'b0, 200, cyc);
    exp_evd++;
    chk("sim_ev_latency", cyc, 2 + BEATS);
    chk("sim_writes_first", log_q.size(), BEATS);
    chk("sim_no_fill_yet", fill_valid_o, 1'b0);
    chk_log(0, 1'b1, 32'h0000_3000, blk);
    @(posedge clk); #1;
    ev_i = 1'b0;
    wait_pulse(1'b1, 200, cyc);
    exp_fill++;
    chk("sim_fill_latency", cyc, 2 + 2 * BEATS);
    chk("sim_total_beats", log_q.size(), 2 * BEATS);
    chk_log(BEATS, 1'b0, 32'h0000_3000, '0);
    chk("sim_fill_addr", fill_addr_o, 32'h0000_3000);
    @(posedge clk); #1;
    req_i = 1'b0;

    // Re-arm: a held request must not start a second refill.
    run_fill(32'h0000_5010, 0, $urandom, 1'b1);
    nreq = 0;
    repeat (40) begin
      @(negedge clk);
      if (mem_if.mem_req_o) nreq++;
    end
    chk("rearm_no_req", nreq, 0);
    @(posedge clk); #1;
    req_i = 1'b0;
    run_fill(32'h0000_5010, 1, $urandom, 1'b0);

    // Randomized mix of transactions.
    repeat (10) begin
      logic [31:0] a = $urandom;
      int          stl = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BEATS; k++) blk[k * 32 +: 32] = $urandom;
        run_evict(a, blk, stl);
      end else begin
        run_fill(a, stl, $urandom, 1'b0);
      end
    end

    // Reset during beat 7 of a refill; the held request restarts from beat 0.
    log_q.delete();
    stall_n = 0;
    salt    = $urandom;
    @(posedge clk); #1;
    req_addr_i = 32'h0000_7788;
    req_i      = 1'b1;
    cyc = 0;
    while (!(mem_if.mem_req_o && mem_if.mem_addr_o == 32'h0000_779C) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reached_beat7", cyc < 100, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", mem_if.mem_req_o, 1'b0);
    chk("midrst_mem_addr", mem_if.mem_addr_o, '0);
    chk("midrst_fill_valid", fill_valid_o, 1'b0);
    chk("midrst_fill_data", fill_data_o, '0);
    chk("midrst_fill_addr", fill_addr_o, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    finish_fill(32'h0000_7788, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("fill_pulse_count", n_fill, exp_fill);
    chk("ev_pulse_count", n_evd, exp_evd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_dma_bridge.md
Name: cache_dma_bridge

Overview:
- Sits directly downstream of Cache, replacing the dummy DMA model.
- Serves Cache miss refills and dirty-block evictions against a narrow word-wide memory bus.
- Evictions: serializes a BLOCK_BITS-wide block into MEM_W write beats.
- Refills: gathers BLOCK_BITS/MEM_W read beats into one block and returns it to Cache with a one-cycle valid pulse.

Parameters:
- BLOCK_BITS, 512, cache block width in bits; must be a multiple of MEM_W.
- MEM_W, 32, memory bus data width in bits; BEATS = BLOCK_BITS/MEM_W (16 by default).
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_addr_i  in  ADDR_W  refill byte address from Cache addr_out_request_DMA_o.
- req_i  in  1  refill request level from Cache request_DMA_o.
- ev_addr_i  in  ADDR_W  eviction byte address from Cache addr_out_evict_DMA_o.
- ev_data_i  in  BLOCK_BITS  eviction block from Cache data_out_evict_DMA_o.
- ev_i  in  1  eviction request level from Cache evict_DMA_o.
- fill_data_o  out  BLOCK_BITS  refilled block, to Cache data_in_request_DMA_i.
- fill_addr_o  out  ADDR_W  block-aligned refill address, to Cache addr_in_request_DMA_i.
- fill_valid_o  out  1  one-cycle pulse, to Cache request_valid_DMA_i.
- ev_done_o  out  1  one-cycle pulse, to Cache evict_DMA_i.
- mem_req_o  out  1  memory beat request, held until accepted.
- mem_we_o  out  1  1 = write beat, 0 = read beat.
- mem_addr_o  out  ADDR_W  beat byte address.
- mem_wdata_o  out  MEM_W  write beat data.
- mem_ready_i  in  1  memory accepts the beat when mem_req_o and mem_ready_i are both high.
- mem_rdata_i  in  MEM_W  read data.
- mem_rvalid_i  in  1  read data valid; earliest one cycle after the read handshake.

Behaviour:
- Reset: fsm=IDLE, beat counter=0, all outputs 0, both re-arm flags=1. Reset mid-transfer abandons the transfer; partial fill data is never presented.
- Block alignment: base = addr with low log2(BLOCK_BITS/8) bits cleared. Beat k address = base + k*(MEM_W/8).
- Beat k maps to block bits [k*MEM_W +: MEM_W] (beat 0 = LSBs).
- One outstanding memory beat at a time; accesses in increasing beat order.
- States: IDLE, EV_BEAT, FL_BEAT, FL_WAIT, EV_DONE, FL_DONE.
- Acceptance in IDLE:
  - A request is accepted only when its re-arm flag is 1.
  - When both ev_i and req_i qualify, ev_i wins: write-back precedes refill, which is safe when the addresses alias.
  - On acceptance, latch address (and ev_data_i), clear that re-arm flag, set beat=0.
  - A re-arm flag is set again on any cycle its request input is low.
- EV_BEAT: mem_req_o=1, mem_we_o=1, addr/wdata = beat k. On handshake: if k==BEATS-1 go to EV_DONE, else k++.
- EV_DONE: ev_done_o=1 for one cycle, then IDLE.
- FL_BEAT: mem_req_o=1, mem_we_o=0. On handshake go to FL_WAIT.
- FL_WAIT: mem_req_o=0. On mem_rvalid_i, store the beat. If last beat go to FL_DONE, else k++ and return to FL_BEAT.
- FL_DONE: fill_valid_o=1 for one cycle with fill_addr_o=base; fill_data_o holds that value until the next fill completes. Then IDLE.
- mem_rvalid_i outside FL_WAIT is ignored.
- Inputs are not re-sampled while busy; Cache holds them stable until its done pulse.
- Zero-wait memory latency:
  - Eviction: 1 (accept) + BEATS + 1 = 18 cycles from ev_i rise to ev_done_o.
  - Refill: 1 + 2*BEATS + 1 = 34 cycles from req_i rise to fill_valid_o.

Optional Feature:
- Macro: CACHE_DMA_BRIDGE_PERF_EN.
- Defined: adds outputs fill_cnt_o[15:0], ev_cnt_o[15:0] and stall_cnt_o[15:0].
  - fill_cnt_o and ev_cnt_o increment on each fill_valid_o and ev_done_o pulse respectively.
  - stall_cnt_o increments each cycle mem_req_o=1 and mem_ready_i=0.
  - All wrap 0xFFFF->0 and reset to 0.
- Undefined: ports and logic absent; functional behaviour identical.

Test Plan:
- Refill: req_i=1 with req_addr_i=0x0000_1234, zero-wait memory returning rdata=beat address -> 16 reads at 0x1200..0x123C; fill_addr_o=0x1200; fill_data_o[31:0]=0x1200, [511:480]=0x123C; fill_valid_o one cycle, 34 cycles after req_i rise.
- Eviction: ev_i=1, ev_addr_i=0x0000_2040, ev_data_i = word k holding 0xA000_0000+k -> writes 0x2040..0x207C with data 0xA0000000..0xA000000F in order; ev_done_o one cycle, 18 cycles after ev_i rise.
- Simultaneous ev_i and req_i at the same address 0x3000 -> all 16 writes complete before the first read; ev_done_o precedes fill_valid_o.
- Back-pressure: mem_ready_i low 3 cycles per beat -> mem_req_o/addr/wdata held stable; completion delayed by exactly 48 cycles; with the macro, stall_cnt_o=48.
- Re-arm: req_i held high after fill_valid_o -> no second refill until req_i is low for at least one cycle and then high again.
- Reset: rst_i pulsed during beat 7 of a refill -> outputs 0 immediately; fill_valid_o never pulses; a held req_i restarts from beat 0 after reset release.
